// File: rtl/controller_sequencer.sv
// controller_sequencer: ring-counter control sequencer for a SAP-1 style CPU.
// A six-state one-hot ring (T1..T6) steps once per clock; the twelve control
// lines are decoded combinationally from the current ring state and the IR
// opcode. Fetch (T1-T3) is identical for every instruction; execute (T4-T6)
// depends on the opcode. HLT freezes the ring at T4 until reset.
//
// Build option: define CTRL_EARLY_END_EN to end OUT and NOP after T4
// (4-cycle instructions). Without it every non-HLT opcode takes 6 cycles.
module controller_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ir_opcode,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic [5:0] t_state,
    output logic       halt
);

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    // Ring positions (bit index into the one-hot state).
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam logic [5:0] T1_ONEHOT = 6'b000001;

    logic [5:0] t_state_q, t_state_d;
    logic       halt_q, halt_d;

    logic is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

    // Opcode classification; anything not explicitly decoded behaves as NOP.
    always_comb begin
        is_lda = (ir_opcode == OP_LDA);
        is_add = (ir_opcode == OP_ADD);
        is_sub = (ir_opcode == OP_SUB);
        is_out = (ir_opcode == OP_OUT);
        is_hlt = (ir_opcode == OP_HLT);
        is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
    end

    // Next ring position and halt flag.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        t_state_d = {t_state_q[4:0], t_state_q[5]};
        halt_d    = halt_q;
        if (halt_q) begin
            t_state_d = t_state_q;
        end else if (t_state_q[T4]) begin
            if (is_hlt) begin
                halt_d    = 1'b1;
                t_state_d = t_state_q;
            end
`ifdef CTRL_EARLY_END_EN
            else if (is_out || is_nop) begin
                t_state_d = T1_ONEHOT;
            end
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            t_state_q <= T1_ONEHOT;
            halt_q    <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halt_q    <= halt_d;
        end
    end

    // Zero-latency control decode from ring position and opcode.
    always_comb begin
        cp = 1'b0;
        ep = 1'b0;
        lm = 1'b0;
        ce = 1'b0;
        li = 1'b0;
        ei = 1'b0;
        la = 1'b0;
        ea = 1'b0;
        su = 1'b0;
        eu = 1'b0;
        lb = 1'b0;
        lo = 1'b0;
        if (!halt_q) begin
            // Fetch: PC -> MAR, PC++, RAM -> IR.
            if (t_state_q[T1]) begin
                ep = 1'b1;
                lm = 1'b1;
            end
            if (t_state_q[T2]) begin
                cp = 1'b1;
            end
            if (t_state_q[T3]) begin
                ce = 1'b1;
                li = 1'b1;
            end
            // Execute: IR address -> MAR for memory-operand instructions.
            if (t_state_q[T4]) begin
                if (is_lda || is_add || is_sub) begin
                    ei = 1'b1;
                    lm = 1'b1;
                end
                if (is_out) begin
                    ea = 1'b1;
                    lo = 1'b1;
                end
            end
            // Operand read: into A for LDA, into B for arithmetic.
            if (t_state_q[T5]) begin
                if (is_lda) begin
                    ce = 1'b1;
                    la = 1'b1;
                end
                if (is_add || is_sub) begin
                    ce = 1'b1;
                    lb = 1'b1;
                end
            end
            // Write back the adder/subtractor result into A.
            if (t_state_q[T6]) begin
                if (is_add || is_sub) begin
                    eu = 1'b1;
                    la = 1'b1;
                end
                if (is_sub) begin
                    su = 1'b1;
                end
            end
        end
    end

    assign t_state = t_state_q;
    assign halt    = halt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer. Each driven cycle pushes the
// expected {t_state, halt, controls} onto a scoreboard; the monitor pops and
// compares on the falling edge. Honours CTRL_EARLY_END_EN like the design.
module tb_controller_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] ir_opcode;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
    logic [5:0] t_state;
    logic       halt;

    controller_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_opcode (ir_opcode),
        .cp        (cp),
        .ep        (ep),
        .lm        (lm),
        .ce        (ce),
        .li        (li),
        .ei        (ei),
        .la        (la),
        .ea        (ea),
        .su        (su),
        .eu        (eu),
        .lb        (lb),
        .lo        (lo),
        .t_state   (t_state),
        .halt      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control masks, order {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}.
    localparam logic [11:0] M_CP = 12'h800;
    localparam logic [11:0] M_EP = 12'h400;
    localparam logic [11:0] M_LM = 12'h200;
    localparam logic [11:0] M_CE = 12'h100;
    localparam logic [11:0] M_LI = 12'h080;
    localparam logic [11:0] M_EI = 12'h040;
    localparam logic [11:0] M_LA = 12'h020;
    localparam logic [11:0] M_EA = 12'h010;
    localparam logic [11:0] M_SU = 12'h008;
    localparam logic [11:0] M_EU = 12'h004;
    localparam logic [11:0] M_LB = 12'h002;
    localparam logic [11:0] M_LO = 12'h001;

    typedef struct {
        string       tag;
        logic [18:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: step 0..5 is T1..T6.
    int   m_step = 0;
    logic m_halt = 1'b0;

`ifdef CTRL_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_ctrl(input int step, input logic [3:0] op, input logic hlt);
        logic [11:0] c;
        c = 12'h000;
        if (!hlt) begin
            case (step)
                0: c = M_EP | M_LM;
                1: c = M_CP;
                2: c = M_CE | M_LI;
                3: begin
                    if (op == 4'h0 || op == 4'h1 || op == 4'h2) c = M_EI | M_LM;
                    else if (op == 4'hE)                        c = M_EA | M_LO;
                end
                4: begin
                    if (op == 4'h0)                    c = M_CE | M_LA;
                    else if (op == 4'h1 || op == 4'h2) c = M_CE | M_LB;
                end
                5: begin
                    if (op == 4'h1)      c = M_EU | M_LA;
                    else if (op == 4'h2) c = M_SU | M_EU | M_LA;
                end
                default: c = 12'h000;
            endcase
        end
        return c;
    endfunction

    function automatic bit is_nop(input logic [3:0] op);
        return !(op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'hE || op == 4'hF);
    endfunction

    task automatic model_edge(input logic [3:0] op, input logic rst);
        if (!rst) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_step == 3 && op == 4'hF)
                m_halt = 1'b1;
            else if (EARLY && m_step == 3 && (op == 4'hE || is_nop(op)))
                m_step = 0;
            else
                m_step = (m_step + 1) % 6;
        end
    endtask

    // Drive one cycle (inputs set just after the previous rising edge).
    task automatic cycle(input logic [3:0] op, input logic rst, input string tag);
        sb_entry_t e;
        ir_opcode = op;
        rst_n     = rst;
        e.tag = tag;
        e.exp = {6'(1 << m_step), m_halt, exp_ctrl(m_step, op, m_halt)};
        sb_q.push_back(e);
        @(posedge clk);
        model_edge(op, rst);
        #1;
    endtask

    // Run one instruction from T1 until the model is back at T1 (bounded).
    task automatic run_instr(input logic [3:0] op, input string tag);
        int n;
        n = 0;
        do begin
            cycle(op, 1'b1, tag);
            n++;
        end while (m_step != 0 && n < 8);
        check({tag, "_len_bound"}, 32'(n < 8), 32'd1);
    endtask

    // Monitor: compare the scoreboard head and structural invariants.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            check(e.tag, {13'd0, t_state, halt, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo},
                  {13'd0, e.exp});
            check({e.tag, "_wbus"}, 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
            check({e.tag, "_onehot"}, 32'($onehot(t_state)), 32'd1);
        end
    end

    initial begin
        rst_n     = 1'b0;
        ir_opcode = 4'h0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held: stays at T1 with ep/lm shown, opcode ignored.
        cycle(4'h1, 1'b0, "reset_hold0");
        cycle(4'hF, 1'b0, "reset_hold1");

        // ADD: full 6 cycles then back to T1.
        run_instr(4'h1, "add");
        cycle(4'h1, 1'b1, "add_wrap_t1");
        cycle(4'h1, 1'b1, "add_wrap_t2");
        cycle(4'h1, 1'b1, "add_wrap_t3");
        cycle(4'h1, 1'b1, "add2_t4");
        cycle(4'h1, 1'b1, "add2_t5");
        cycle(4'h1, 1'b1, "add2_t6");

        // SUB, then OUT, then NOP, then LDA with garbage opcode during fetch.
        run_instr(4'h2, "sub");
        run_instr(4'hE, "out");
        run_instr(4'h7, "nop");
        cycle(4'hF, 1'b1, "fetch_ign_t1");
        cycle(4'hE, 1'b1, "fetch_ign_t2");
        cycle(4'h2, 1'b1, "fetch_ign_t3");
        cycle(4'h0, 1'b1, "lda_t4");
        cycle(4'h0, 1'b1, "lda_t5");
        cycle(4'h0, 1'b1, "lda_t6");

        // Reset during T5 of LDA: next cycle is T1, la never asserted in T6.
        cycle(4'h0, 1'b1, "lda_r_t1");
        cycle(4'h0, 1'b1, "lda_r_t2");
        cycle(4'h0, 1'b1, "lda_r_t3");
        cycle(4'h0, 1'b1, "lda_r_t4");
        cycle(4'h0, 1'b0, "lda_r_t5");
        cycle(4'h0, 1'b1, "lda_r_after");
        check("lda_r_la_low", 32'(la), 32'd0);
        run_instr(4'h0, "lda_r_rest");

        // HLT: freeze at T4 for 20 edges with toggling opcode, then reset.
        cycle(4'hF, 1'b1, "hlt_t1");
        cycle(4'hF, 1'b1, "hlt_t2");
        cycle(4'hF, 1'b1, "hlt_t3");
        cycle(4'hF, 1'b1, "hlt_t4");
        for (int i = 0; i < 20; i++) begin
            cycle((i % 2) ? 4'h2 : 4'hE, 1'b1, "halted");
        end
        cycle(4'h1, 1'b0, "halt_reset");
        cycle(4'h1, 1'b1, "post_halt_t1");

        // Random opcodes; occasional reset, forced reset when halted.
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] op;
            logic       r;
            op = 4'($urandom_range(0, 15));
            r  = !(m_halt || ($urandom_range(0, 63) == 0));
            cycle(op, r, "random");
        end

        @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
